result_display: RTL and testbench
=================================

// Module: result_display
// PURPOSE
//  Consumer end of the calculator ALU result interface: accepts result magnitude and flags (SF, ZF, DZF),
//  converts the magnitude to BCD sequentially, and drives a 3-digit time-multiplexed 7-segment display.
//  Sits between the ALU result/flag outputs and the board display pins.
// PARAMETERS
//  RES_W        6       result magnitude width; legal 3..6 (max 63, always fits two decimal digits)
//  REFRESH_DIV  50000   clk cycles each digit is enabled per scan step
//  BLINK_DIV    25000000 clk cycles per error-blink half period (used only with BLINK_ERR_EN)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous, active-high reset
//  res_valid  in   1      result/flags on res_* are valid
//  res_ready  out  1      block can accept a result; transfer when res_valid & res_ready at clk edge
//  res_mag    in   RES_W  unsigned result magnitude
//  res_sf     in   1      sign flag (1 = negative)
//  res_zf     in   1      zero flag
//  res_dzf    in   1      divide-by-zero flag
//  busy       out  1      1 while a BCD conversion is in progress
//  seg_n      out  7      active-low segments {g,f,e,d,c,b,a}
//  an_n       out  3      active-low digit enables; an_n[2]=left (sign), [1]=tens, [0]=units
// BEHAVIOUR
//  - One clock; reset synchronous, active-high; clk/rst as named above.
//  - Reset: state BLANK, res_ready=1, busy=0, seg_n=7'h7F, an_n=3'b111, scan/refresh/blink counters=0.
//  - FSM: BLANK -> (accept) -> CONV -> (RES_W shift steps done) -> SHOW -> (accept) -> CONV.
//    res_ready=1 in BLANK and SHOW, 0 in CONV. busy=1 exactly in CONV.
//  - Accept cycle latches res_mag, res_sf, res_zf, res_dzf into holding regs; inputs ignored afterwards.
//  - CONV: double-dabble, one shift (with add-3 correction) per cycle, RES_W cycles; SHOW entered on
//    cycle RES_W+1 after accept; displayed value switches atomically on SHOW entry (old value held in CONV).
//  - If res_dzf latched: conversion still runs for timing uniformity; display shows "Err".
//  - Display priority: DZF -> "E","r","r"; else ZF -> blank, blank, "0" (magnitude ignored);
//    else sign digit '-' (g only) if SF else blank; tens digit blank when 0; units always shown.
//  - Scan: refresh counter wraps at REFRESH_DIV-1, then digit index advances 0->1->2->0; exactly one
//    an_n bit low per cycle in SHOW/CONV-after-first-result; in BLANK an_n=3'b111, seg_n=7'h7F.
//  - Segment/anode update on same edge (no ghosting cycle where anode and segments mismatch).
//  - Reset mid-CONV: abort, return to BLANK; partial BCD discarded.
//  - res_valid held high in CONV: not accepted; accepted on first SHOW cycle.
// CONFIGURATION
//  BLINK_ERR_EN defined: in "Err" display, all anodes forced high during alternate BLINK_DIV
//   half periods (blink counter free-runs from reset, phase 0 = visible).
//  BLINK_ERR_EN undefined: "Err" shown steadily; no blink counter synthesised; BLINK_DIV unused.
// STRUCTURE
//  Shared package calc_pkg: 7-seg glyph constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_R, SEG_BLANK),
//   FSM state typedef (BLANK, CONV, SHOW), digit-index constants.
//  Sub-module bin2bcd_seq: start/done sequential double-dabble, RES_W-bit in, 4-bit tens/units out.
//  Top holds FSM, holding regs, refresh/scan counters, glyph mux, optional blink counter.
// TESTING (REFRESH_DIV=4 for sim)
//  1 After rst: seg_n=7'h7F, an_n=3'b111, res_ready=1 for >=20 cycles with no input.
//  2 mag=49, sf=0 -> busy 6 cycles; then units an_n=3'b110 seg "9", tens 3'b101 "4", sign 3'b011 blank.
//  3 mag=3, sf=1 -> sign digit '-' (seg_n=7'b0111111), tens blank, units "3".
//  4 dzf=1, mag=0 -> "E","r","r"; with BLINK_ERR_EN and BLINK_DIV=8, an_n=3'b111 on alternate 8-cycle windows.
//  5 zf=1, mag=5 (inconsistent) -> displays "0" only; res_valid held during CONV -> second accepted on first SHOW cycle.
//  6 rst asserted 3 cycles into CONV -> next cycle BLANK, busy=0, outputs at reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator display types: FSM states, digit indices and active-low 7-segment glyphs {g,f,e,d,c,b,a}.
// Pure constants and a combinational glyph lookup; no latency, no flow control.
package calc_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        CONV  = 2'd1,
        SHOW  = 2'd2
    } disp_state_e;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_SIGN  = 2'd2;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = SEG_0;
            4'd1:    seg_digit = SEG_1;
            4'd2:    seg_digit = SEG_2;
            4'd3:    seg_digit = SEG_3;
            4'd4:    seg_digit = SEG_4;
            4'd5:    seg_digit = SEG_5;
            4'd6:    seg_digit = SEG_6;
            4'd7:    seg_digit = SEG_7;
            4'd8:    seg_digit = SEG_8;
            4'd9:    seg_digit = SEG_9;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start_i loads bin_i, then one add-3/shift per cycle for RES_W cycles.
// done_o pulses during the last shift cycle with tens_o/units_o already final; no backpressure.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int RES_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [RES_W-1:0] bin_i,
    output logic             done_o,
    output logic [3:0]       tens_o,
    output logic [3:0]       units_o
);

    logic [RES_W-1:0] bin_q, bin_d;
    logic [3:0]       tens_q, tens_d, units_q, units_d;
    logic [3:0]       tens_adj, units_adj;
    logic [2:0]       cnt_q, cnt_d;

    always_comb begin
        tens_adj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
        units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
        bin_d     = bin_q;
        tens_d    = tens_q;
        units_d   = units_q;
        cnt_d     = cnt_q;
        if (start_i) begin
            bin_d   = bin_i;
            tens_d  = 4'd0;
            units_d = 4'd0;
            cnt_d   = 3'(RES_W);
        end else if (cnt_q != 3'd0) begin
            // Max input 63 keeps tens below 8, so the bit shifted out of tens is always zero.
            {tens_d, units_d, bin_d} = {tens_adj, units_adj, bin_q} << 1;
            cnt_d = cnt_q - 3'd1;
        end
    end

    assign done_o  = (cnt_q == 3'd1) && !start_i;
    assign tens_o  = tens_d;
    assign units_o = units_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            cnt_q   <= 3'd0;
        end else begin
            bin_q   <= bin_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/result_display.sv
// ALU result consumer: latch result on valid&ready, BCD-convert in RES_W cycles, scan 3-digit 7-seg display.
// res_ready is low only during conversion; BLINK_ERR_EN blinks the "Err" display every BLINK_DIV cycles.
module result_display
    import calc_pkg::*;
#(
    parameter int RES_W       = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [RES_W-1:0] res_mag,
    input  logic             res_sf,
    input  logic             res_zf,
    input  logic             res_dzf,
    output logic             busy,
    output logic [6:0]       seg_n,
    output logic [2:0]       an_n
);

    localparam int RFW = ($clog2(REFRESH_DIV) > 0) ? $clog2(REFRESH_DIV) : 1;

    if (RES_W < 3 || RES_W > 6) begin : g_bad_res_w
        $error("result_display: RES_W must be 3..6");
    end
    if (REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_bad_div
        $error("result_display: dividers must be at least 1");
    end

    disp_state_e    state_q, state_d;
    logic           hold_sf_q, hold_sf_d, hold_zf_q, hold_zf_d, hold_dzf_q, hold_dzf_d;
    logic           shown_vld_q, shown_vld_d, shown_sf_q, shown_sf_d;
    logic           shown_zf_q, shown_zf_d, shown_dzf_q, shown_dzf_d;
    logic [3:0]     shown_tens_q, shown_tens_d, shown_units_q, shown_units_d;
    logic [RFW-1:0] refresh_q, refresh_d;
    logic [1:0]     scan_q, scan_d;
    logic [6:0]     seg_q, seg_d;
    logic [2:0]     an_q, an_d;
    logic           accept, conv_done, blink_dark;
    logic [3:0]     bcd_tens, bcd_units;

    assign res_ready = (state_q != CONV);
    assign busy      = (state_q == CONV);
    assign accept    = res_valid && res_ready;
    assign seg_n     = seg_q;
    assign an_n      = an_q;

    bin2bcd_seq #(.RES_W(RES_W)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept),
        .bin_i   (res_mag),
        .done_o  (conv_done),
        .tens_o  (bcd_tens),
        .units_o (bcd_units)
    );

`ifdef BLINK_ERR_EN
    localparam int BLW = ($clog2(BLINK_DIV) > 0) ? $clog2(BLINK_DIV) : 1;
    logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BLW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blink_dark = blink_ph_d;
`else
    assign blink_dark = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        hold_sf_d     = hold_sf_q;
        hold_zf_d     = hold_zf_q;
        hold_dzf_d    = hold_dzf_q;
        shown_vld_d   = shown_vld_q;
        shown_sf_d    = shown_sf_q;
        shown_zf_d    = shown_zf_q;
        shown_dzf_d   = shown_dzf_q;
        shown_tens_d  = shown_tens_q;
        shown_units_d = shown_units_q;

        case (state_q)
            BLANK, SHOW: begin
                if (accept) begin
                    state_d    = CONV;
                    hold_sf_d  = res_sf;
                    hold_zf_d  = res_zf;
                    hold_dzf_d = res_dzf;
                end
            end
            CONV: begin
                // The shown value switches in one edge so CONV keeps displaying the old result.
                if (conv_done) begin
                    state_d       = SHOW;
                    shown_vld_d   = 1'b1;
                    shown_sf_d    = hold_sf_q;
                    shown_zf_d    = hold_zf_q;
                    shown_dzf_d   = hold_dzf_q;
                    shown_tens_d  = bcd_tens;
                    shown_units_d = bcd_units;
                end
            end
            default: state_d = BLANK;
        endcase

        refresh_d = refresh_q + 1'b1;
        scan_d    = scan_q;
        if (refresh_q == RFW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            scan_d    = (scan_q == DIG_SIGN) ? DIG_UNITS : scan_q + 2'd1;
        end

        // Glyph and anode are derived from the same next-state values so they change together.
        seg_d = SEG_BLANK;
        an_d  = 3'b111;
        if (shown_vld_d) begin
            an_d = ~(3'b001 << scan_d);
            case (scan_d)
                DIG_UNITS: seg_d = shown_dzf_d ? SEG_R :
                                   shown_zf_d  ? SEG_0 : seg_digit(shown_units_d);
                DIG_TENS:  seg_d = shown_dzf_d ? SEG_R :
                                   (shown_zf_d || shown_tens_d == 4'd0) ? SEG_BLANK :
                                   seg_digit(shown_tens_d);
                DIG_SIGN:  seg_d = shown_dzf_d ? SEG_E :
                                   (!shown_zf_d && shown_sf_d) ? SEG_MINUS : SEG_BLANK;
                default:   seg_d = SEG_BLANK;
            endcase
            if (shown_dzf_d && blink_dark) begin
                an_d = 3'b111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BLANK;
            hold_sf_q     <= 1'b0;
            hold_zf_q     <= 1'b0;
            hold_dzf_q    <= 1'b0;
            shown_vld_q   <= 1'b0;
            shown_sf_q    <= 1'b0;
            shown_zf_q    <= 1'b0;
            shown_dzf_q   <= 1'b0;
            shown_tens_q  <= 4'd0;
            shown_units_q <= 4'd0;
            refresh_q     <= '0;
            scan_q        <= DIG_UNITS;
            seg_q         <= SEG_BLANK;
            an_q          <= 3'b111;
        end else begin
            state_q       <= state_d;
            hold_sf_q     <= hold_sf_d;
            hold_zf_q     <= hold_zf_d;
            hold_dzf_q    <= hold_dzf_d;
            shown_vld_q   <= shown_vld_d;
            shown_sf_q    <= shown_sf_d;
            shown_zf_q    <= shown_zf_d;
            shown_dzf_q   <= shown_dzf_d;
            shown_tens_q  <= shown_tens_d;
            shown_units_q <= shown_units_d;
            refresh_q     <= refresh_d;
            scan_q        <= scan_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with REFRESH_DIV=4 and BLINK_DIV=8.
module tb_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [5:0] res_mag = 6'd0;
    logic       res_sf = 1'b0, res_zf = 1'b0, res_dzf = 1'b0;
    logic       busy;
    logic [6:0] seg_n;
    logic [2:0] an_n;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_at [3];
    bit         seen   [3];
    int         dark, multi;

    result_display #(.RES_W(6), .REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
        .res_mag(res_mag), .res_sf(res_sf), .res_zf(res_zf), .res_dzf(res_dzf),
        .busy(busy), .seg_n(seg_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records, per anode, the segment pattern seen over n cycles.
    task automatic observe(input int n);
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0;
            seg_at[k] = 7'h00;
        end
        dark = 0;
        multi = 0;
        repeat (n) begin
            tick();
            case (an_n)
                3'b110:  begin seen[0] = 1'b1; seg_at[0] = seg_n; end
                3'b101:  begin seen[1] = 1'b1; seg_at[1] = seg_n; end
                3'b011:  begin seen[2] = 1'b1; seg_at[2] = seg_n; end
                3'b111:  dark++;
                default: multi++;
            endcase
        end
    endtask

    task automatic send(input logic [5:0] mag, input logic sf, input logic zf, input logic dzf);
        res_mag = mag; res_sf = sf; res_zf = zf; res_dzf = dzf; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic busy_cycles(output int c);
        c = 0;
        while (busy && c < 40) begin
            c++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL rst_seg: got %h want 7f", seg_n); end
        total++; if (an_n !== 3'b111) begin bad++; $display("FAIL rst_an: got %b want 111", an_n); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", res_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        observe(20);
        total++; if (dark !== 20) begin bad++; $display("FAIL idle_dark: got %0d want 20", dark); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", res_ready); end
    endtask

    task automatic test_positive();
        int c;
        send(6'd49, 1'b0, 1'b0, 1'b0);
        busy_cycles(c);
        total++; if (c !== 6) begin bad++; $display("FAIL pos_busy_len: got %0d want 6", c); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL pos_ready: got %b want 1", res_ready); end
        observe(16);
        total++; if (!seen[0] || seg_at[0] !== 7'h10) begin bad++; $display("FAIL pos_units: got %h want 10", seg_at[0]); end
        total++; if (!seen[1] || seg_at[1] !== 7'h19) begin bad++; $display("FAIL pos_tens: got %h want 19", seg_at[1]); end
        total++; if (!seen[2] || seg_at[2] !== 7'h7F) begin bad++; $display("FAIL pos_sign: got %h want 7f", seg_at[2]); end
        total++; if (dark !== 0 || multi !== 0) begin bad++; $display("FAIL pos_anodes: got dark=%0d multi=%0d want 0 0", dark, multi); end
    endtask

    task automatic test_negative();
        int c;
        send(6'd3, 1'b1, 1'b0, 1'b0);
        total++; if (res_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL neg_conv_flags: got ready=%b busy=%b want 0 1", res_ready, busy); end
        observe(5);
        total++; if (seen[0] && seg_at[0] !== 7'h10) begin bad++; $display("FAIL neg_held_units: got %h want 10", seg_at[0]); end
        total++; if (seen[1] && seg_at[1] !== 7'h19) begin bad++; $display("FAIL neg_held_tens: got %h want 19", seg_at[1]); end
        total++; if (dark + multi !== 0) begin bad++; $display("FAIL neg_held_anodes: got %0d bad cycles want 0", dark + multi); end
        busy_cycles(c);
        total++; if (c !== 1) begin bad++; $display("FAIL neg_busy_tail: got %0d want 1", c); end
        observe(16);
        total++; if (!seen[2] || seg_at[2] !== 7'h3F) begin bad++; $display("FAIL neg_sign: got %h want 3f", seg_at[2]); end
        total++; if (!seen[1] || seg_at[1] !== 7'h7F) begin bad++; $display("FAIL neg_tens: got %h want 7f", seg_at[1]); end
        total++; if (!seen[0] || seg_at[0] !== 7'h30) begin bad++; $display("FAIL neg_units: got %h want 30", seg_at[0]); end
    endtask

    task automatic test_err();
        int c;
        int exp_dark;
        int n;
`ifdef BLINK_ERR_EN
        exp_dark = 32;
        n = 64;
`else
        exp_dark = 0;
        n = 16;
`endif
        send(6'd0, 1'b0, 1'b0, 1'b1);
        busy_cycles(c);
        total++; if (c !== 6) begin bad++; $display("FAIL err_busy_len: got %0d want 6", c); end
        observe(n);
        total++; if (!seen[2] || seg_at[2] !== 7'h06) begin bad++; $display("FAIL err_e: got %h want 06", seg_at[2]); end
        total++; if (!seen[1] || seg_at[1] !== 7'h2F) begin bad++; $display("FAIL err_r_tens: got %h want 2f", seg_at[1]); end
        total++; if (!seen[0] || seg_at[0] !== 7'h2F) begin bad++; $display("FAIL err_r_units: got %h want 2f", seg_at[0]); end
        total++; if (dark !== exp_dark || multi !== 0) begin bad++; $display("FAIL err_blink: got dark=%0d multi=%0d want %0d 0", dark, multi, exp_dark); end
    endtask

    task automatic test_zero_back_to_back();
        int c;
        res_mag = 6'd5; res_sf = 1'b0; res_zf = 1'b1; res_dzf = 1'b0; res_valid = 1'b1;
        tick();
        res_mag = 6'd7; res_zf = 1'b0;
        busy_cycles(c);
        total++; if (c !== 6) begin bad++; $display("FAIL zf_busy_len: got %0d want 6", c); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL zf_show_ready: got %b want 1", res_ready); end
        tick();
        res_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        observe(5);
        total++; if (seen[0] && seg_at[0] !== 7'h40) begin bad++; $display("FAIL zf_units: got %h want 40", seg_at[0]); end
        total++; if (seen[1] && seg_at[1] !== 7'h7F) begin bad++; $display("FAIL zf_tens: got %h want 7f", seg_at[1]); end
        total++; if (seen[2] && seg_at[2] !== 7'h7F) begin bad++; $display("FAIL zf_sign: got %h want 7f", seg_at[2]); end
        busy_cycles(c);
        total++; if (c !== 1) begin bad++; $display("FAIL b2b_busy_tail: got %0d want 1", c); end
        observe(16);
        total++; if (!seen[0] || seg_at[0] !== 7'h78) begin bad++; $display("FAIL b2b_units: got %h want 78", seg_at[0]); end
        total++; if (!seen[1] || seg_at[1] !== 7'h7F) begin bad++; $display("FAIL b2b_tens: got %h want 7f", seg_at[1]); end
        total++; if (!seen[2] || seg_at[2] !== 7'h7F) begin bad++; $display("FAIL b2b_sign: got %h want 7f", seg_at[2]); end
    endtask

    task automatic test_reset_mid_conv();
        int c;
        send(6'd49, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", res_ready); end
        total++; if (seg_n !== 7'h7F || an_n !== 3'b111) begin bad++; $display("FAIL abort_outputs: got seg=%h an=%b want 7f 111", seg_n, an_n); end
        rst = 1'b0;
        observe(12);
        total++; if (dark !== 12) begin bad++; $display("FAIL abort_blank: got %0d want 12", dark); end
        send(6'd25, 1'b0, 1'b0, 1'b0);
        busy_cycles(c);
        total++; if (c !== 6) begin bad++; $display("FAIL recover_busy_len: got %0d want 6", c); end
        observe(16);
        total++; if (!seen[0] || seg_at[0] !== 7'h12) begin bad++; $display("FAIL recover_units: got %h want 12", seg_at[0]); end
        total++; if (!seen[1] || seg_at[1] !== 7'h24) begin bad++; $display("FAIL recover_tens: got %h want 24", seg_at[1]); end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_err();
        test_zero_back_to_back();
        test_reset_mid_conv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
